// File: rtl/morph_filter.sv
// Binary dilation/erosion of a valid-qualified 1-bit mask raster over a
// WIN_SIZE x WIN_SIZE window with a structuring element latched at each frame start.
module morph_filter #(
    parameter int H_IMG_RES = 640,
    parameter int V_IMG_RES = 480,
    parameter int WIN_SIZE  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode,
    input  logic [WIN_SIZE*WIN_SIZE-1:0] struct_elm,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic                         in_pix,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic                         out_sof,
    output logic                         out_pix,
    output logic                         frame_err
);
    localparam int R     = WIN_SIZE / 2;
    localparam int NB    = WIN_SIZE + 1;
    localparam int LAT   = R * H_IMG_RES + R;
    localparam int NPIX  = H_IMG_RES * V_IMG_RES;
    localparam int TOTAL = NPIX + LAT;
    localparam int SW    = $clog2(TOTAL + 1);
    localparam int XW    = $clog2(H_IMG_RES);
    localparam int YW    = $clog2(V_IMG_RES + R + 2);
    localparam int BW    = $clog2(NB);
    localparam int NT    = WIN_SIZE * WIN_SIZE;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     s, bs;
    logic [XW-1:0]     xs, bx, cx, bcx, wcx;
    logic [YW-1:0]     ys, by, cy, bcy, wcy;
    logic [BW-1:0]     wsel, bw;
    logic              mode_q;
    logic [NT-1:0]     se_q;
    logic [NT-1:0]     win;
    logic              win_v, win_sof;
    logic [H_IMG_RES-1:0] lbuf [NB];

    logic              start, abort, adv, keep, last_x, emit, emit_sof;
    logic [WIN_SIZE-1:0] new_col;
    logic              dil, ero, red, tap, row_ok, col_ok;

    assign in_ready = (state != FLUSH);

    always_comb begin
        start    = in_valid && in_sof && (state != FLUSH);
        abort    = start && (state == RUN);
        adv      = start || (state == RUN && in_valid) || (state == FLUSH);
        keep     = adv && (state != FLUSH);
        // A new sof restarts every position counter from zero on its own pixel.
        bs       = start ? '0 : s;
        bx       = start ? '0 : xs;
        by       = start ? '0 : ys;
        bw       = start ? '0 : wsel;
        bcx      = start ? '0 : cx;
        bcy      = start ? '0 : cy;
        last_x   = (bx == XW'(H_IMG_RES - 1));
        emit     = (bs >= SW'(LAT));
        emit_sof = (bs == SW'(LAT));
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (adv && !start && bs == SW'(NPIX - 1)) state_nxt = FLUSH;
            FLUSH:   if (bs == SW'(TOTAL - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Right-hand window column: older rows come from the line buffers, newest from in_pix.
    always_comb begin
        new_col = '0;
        for (int unsigned r = 0; r < WIN_SIZE - 1; r++) begin
            new_col[r] = lbuf[BW'((int'(bw) + NB - (WIN_SIZE - 1 - int'(r))) % NB)][bx];
        end
        new_col[WIN_SIZE-1] = in_pix;
    end

    // Taps outside the image are replaced by the neutral value using the center position.
    always_comb begin
        dil    = 1'b0;
        ero    = 1'b1;
        tap    = 1'b0;
        row_ok = 1'b0;
        col_ok = 1'b0;
        for (int unsigned r = 0; r < WIN_SIZE; r++) begin
            for (int unsigned c = 0; c < WIN_SIZE; c++) begin
                row_ok = (int'(wcy) + int'(r) >= R) && (int'(wcy) + int'(r) < V_IMG_RES + R);
                col_ok = (int'(wcx) + int'(c) >= R) && (int'(wcx) + int'(c) < H_IMG_RES + R);
                tap    = (row_ok && col_ok) ? win[WIN_SIZE*r+c] : mode_q;
                dil    = dil | (se_q[WIN_SIZE*r+c] & tap);
                ero    = ero & (~se_q[WIN_SIZE*r+c] | tap);
            end
        end
        red = mode_q ? ero : dil;
    end

    always_ff @(posedge clk) begin
        if (keep) lbuf[bw][bx] <= in_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '0;
            xs        <= '0;
            ys        <= '0;
            wsel      <= '0;
            cx        <= '0;
            cy        <= '0;
            mode_q    <= 1'b0;
            se_q      <= '0;
            win       <= '0;
            win_v     <= 1'b0;
            win_sof   <= 1'b0;
            wcx       <= '0;
            wcy       <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_pix   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= abort;
            if (start) begin
                mode_q <= mode;
                se_q   <= struct_elm;
            end
            if (adv) begin
                s    <= bs + 1'b1;
                xs   <= last_x ? '0 : bx + 1'b1;
                ys   <= last_x ? by + 1'b1 : by;
                wsel <= !last_x ? bw : (bw == BW'(NB - 1)) ? '0 : bw + 1'b1;
                if (emit) begin
                    cx <= (bcx == XW'(H_IMG_RES - 1)) ? '0 : bcx + 1'b1;
                    cy <= (bcx == XW'(H_IMG_RES - 1)) ? bcy + 1'b1 : bcy;
                end else begin
                    cx <= bcx;
                    cy <= bcy;
                end
                for (int unsigned r = 0; r < WIN_SIZE; r++) begin
                    for (int unsigned c = 0; c < WIN_SIZE - 1; c++) begin
                        win[WIN_SIZE*r+c] <= win[WIN_SIZE*r+c+1];
                    end
                    win[WIN_SIZE*r+WIN_SIZE-1] <= new_col[r];
                end
                win_v   <= emit;
                win_sof <= emit_sof;
                wcx     <= bcx;
                wcy     <= bcy;
            end else begin
                win_v <= 1'b0;
            end
            // An aborting sof also kills the result still in the reduction stage.
            out_valid <= win_v && !abort;
            out_sof   <= win_v && win_sof && !abort;
            out_pix   <= win_v && !abort && red;
        end
    end
endmodule

// File: tb/tb_morph_filter.sv
// Randomized self-checking bench for morph_filter against a direct
// neighbourhood-evaluation reference model (8x6 image, 3x3 window).
module tb_morph_filter;
    localparam int H   = 8;
    localparam int V   = 6;
    localparam int W   = 3;
    localparam int R   = 1;
    localparam int N   = H * V;
    localparam int LAT = R * H + R;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [8:0] struct_elm;
    logic       in_valid, in_sof, in_pix;
    logic       in_ready, out_valid, out_sof, out_pix, frame_err;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned first_out_cyc;
    int unsigned acc9;
    int err_cnt;
    int lowc;
    bit all_q[$];
    bit sof_q[$];
    bit img_a[N];
    bit img_b[N];
    logic [8:0] se_r;
    bit md_r;

    morph_filter #(.H_IMG_RES(H), .V_IMG_RES(V), .WIN_SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .struct_elm(struct_elm),
        .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
        .in_ready(in_ready), .out_valid(out_valid), .out_sof(out_sof),
        .out_pix(out_pix), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            all_q.push_back(out_pix);
            sof_q.push_back(out_sof);
            if (first_out_cyc == 0) first_out_cyc = cyc;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output at (x,y): evaluate the neighbourhood directly, neutral value off-image.
    function automatic bit ref_pix(input bit img[N], input bit md, input logic [8:0] se,
                                   input int x, input int y);
        bit acc = md;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                int yy = y + r - R;
                int xx = x + c - R;
                bit t = (yy >= 0 && yy < V && xx >= 0 && xx < H) ? img[yy*H+xx] : md;
                if (se[W*r+c]) acc = md ? (acc & t) : (acc | t);
            end
        end
        return acc;
    endfunction

    task automatic send(input bit img[N], input bit md, input logic [8:0] se,
                        input int gap, input int npix);
        for (int p = 0; p < npix; p++) begin
            bit acc = 1'b0;
            int tries = 0;
            while (!acc) begin
                in_valid = ($urandom_range(99) >= gap);
                in_pix   = in_valid ? img[p] : 1'($urandom);
                in_sof   = in_valid ? (p == 0) : 1'($urandom);
                if (p == 0) begin
                    mode = md;
                    struct_elm = se;
                end else begin
                    mode = 1'($urandom);
                    struct_elm = 9'($urandom);
                end
                acc = in_valid && in_ready;
                if (acc && p == LAT) acc9 = cyc;
                @(posedge clk);
                #1;
                tries++;
                if (tries > 300) begin
                    $display("FAIL send_timeout: got %0d, expected accept", tries);
                    $fatal(1);
                end
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic measure_flush();
        lowc = 0;
        while (in_ready !== 1'b1 && lowc < 50) begin
            lowc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input bit img[N], input bit md,
                               input logic [8:0] se, input int base);
        check({tag, "_count"}, all_q.size(), base + N);
        if (all_q.size() == base + N) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("%s_pix%0d", tag, i), all_q[base+i], ref_pix(img, md, se, i % H, i / H));
                check($sformatf("%s_sof%0d", tag, i), sof_q[base+i], (i == 0));
            end
        end
    endtask

    task automatic run_frame(input string tag, input bit img[N], input bit md,
                             input logic [8:0] se, input int gap);
        all_q.delete();
        sof_q.delete();
        first_out_cyc = 0;
        send(img, md, se, gap, N);
        measure_flush();
        check({tag, "_flush"}, lowc, LAT);
        repeat (6) @(posedge clk);
        #1;
        check_frame(tag, img, md, se, 0);
        check({tag, "_lat"}, first_out_cyc - acc9, 2);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; struct_elm = '0;
        in_valid = 1'b0; in_sof = 1'b0; in_pix = 1'b0;
        first_out_cyc = 0; acc9 = 0; err_cnt = 0;
        #23;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_pix", out_pix, 0);
        check("rst_err", frame_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel dilated by a cross.
        foreach (img_a[i]) img_a[i] = 1'b0;
        img_a[2*H+3] = 1'b1;
        run_frame("dil_cross", img_a, 1'b0, 9'b010111010, 0);
        if (all_q.size() == N) begin
            int ones = 0;
            foreach (all_q[i]) ones += int'(all_q[i]);
            check("dil_cross_ones", ones, 5);
            check("dil_cross_31", all_q[1*H+3], 1);
            check("dil_cross_22", all_q[2*H+2], 1);
            check("dil_cross_42", all_q[2*H+4], 1);
            check("dil_cross_33", all_q[3*H+3], 1);
        end

        // Same frame with ~50% input gaps.
        run_frame("dil_gap", img_a, 1'b0, 9'b010111010, 50);

        foreach (img_b[i]) img_b[i] = 1'b1;
        run_frame("ero_ones", img_b, 1'b1, 9'h1FF, 0);

        foreach (img_b[i]) img_b[i] = 1'b0;
        for (int y = 2; y < 4; y++) for (int x = 2; x < 4; x++) img_b[y*H+x] = 1'b1;
        run_frame("ero_block", img_b, 1'b1, 9'h1FF, 0);
        run_frame("dil_block", img_b, 1'b0, 9'h1FF, 30);
        run_frame("ero_empty_se", img_b, 1'b1, 9'h000, 20);

        for (int f = 0; f < 4; f++) begin
            foreach (img_b[i]) img_b[i] = ($urandom_range(99) < 35);
            se_r = 9'($urandom);
            md_r = 1'($urandom);
            run_frame($sformatf("rand%0d", f), img_b, md_r, se_r, 50);
        end

        // Sof in the middle of a frame abandons it.
        foreach (img_a[i]) img_a[i] = ($urandom_range(99) < 40);
        foreach (img_b[i]) img_b[i] = ($urandom_range(99) < 40);
        all_q.delete();
        sof_q.delete();
        err_cnt = 0;
        send(img_a, 1'b0, 9'h1FF, 0, 20);
        send(img_b, 1'b1, 9'b010111010, 0, N);
        measure_flush();
        repeat (6) @(posedge clk);
        #1;
        check("abort_err", err_cnt, 1);
        check("abort_total", all_q.size(), 10 + N);
        if (all_q.size() == 10 + N) begin
            for (int i = 0; i < 10; i++)
                check($sformatf("abort_old%0d", i), all_q[i], ref_pix(img_a, 1'b0, 9'h1FF, i % H, i / H));
            check("abort_old_sof", sof_q[0], 1);
        end
        check_frame("abort_new", img_b, 1'b1, 9'b010111010, 10);

        // Asynchronous reset mid-frame.
        send(img_a, 1'b0, 9'h1FF, 0, 25);
        check("prerst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_pix", out_pix, 0);
        check("arst_sof", out_sof, 0);
        check("arst_ready", in_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        all_q.delete();
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_pix   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_quiet", all_q.size(), 0);
        foreach (img_b[i]) img_b[i] = ($urandom_range(99) < 30);
        run_frame("postrst", img_b, 1'b0, 9'b010111010, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
